// File: rtl/zynq_gp0_csr_pkg.sv
// Shared constants for the GP0 AXI4-Lite CSR bridge: word-offset decode
// values, AXI response codes and the FIFO count width helper.
package zynq_gp0_csr_pkg;

  // Word indices (byte address bits [7:2]) of the FIFO windows
  localparam logic [5:0] IDX_PS2PL_PUSH = 6'h10;
  localparam logic [5:0] IDX_PS2PL_FREE = 6'h11;
  localparam logic [5:0] IDX_PL2PS_POP  = 6'h12;
  localparam logic [5:0] IDX_PL2PS_OCC  = 6'h13;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  function automatic int cnt_w(input int els);
    return $clog2(els + 1);
  endfunction

endpackage

// File: rtl/zynq_gp0_csr_fifo.sv
// Single-clock 1R1W word FIFO with occupancy count. Push to full and pop of
// empty are silently ignored; there is no bypass from push to head.
module zynq_gp0_csr_fifo
  import zynq_gp0_csr_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ELS    = 8,
  localparam int CNT_W = cnt_w(ELS)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  output logic [DATA_W-1:0] head_data,
  output logic [CNT_W-1:0]  count,
  output logic              full,
  output logic              empty
);

  localparam int PTR_W = (ELS > 1) ? $clog2(ELS) : 1;

  logic [DATA_W-1:0] mem_q [ELS];
  logic [PTR_W-1:0]  wr_ptr_q;
  logic [PTR_W-1:0]  rd_ptr_q;
  logic [CNT_W-1:0]  count_q;
  logic              do_push;
  logic              do_pop;

  assign full    = (count_q == CNT_W'(ELS));
  assign empty   = (count_q == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;

  // Pointers wrap naturally because ELS is a power of two
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      if (do_push && !do_pop) begin
        count_q <= count_q + CNT_W'(1);
      end else if (do_pop && !do_push) begin
        count_q <= count_q - CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data;
  end

  assign head_data = mem_q[rd_ptr_q];
  assign count     = count_q;

endmodule

// File: rtl/zynq_gp0_axil_csr_bridge.sv
// AXI4-Lite slave behind PS GP0: NUM_CSR read/write control registers plus a
// PS->PL command FIFO and a PL->PS response FIFO mapped at 0x40..0x4C.
module zynq_gp0_axil_csr_bridge
  import zynq_gp0_csr_pkg::*;
#(
  parameter int C_AXI_DATA_WIDTH = 32,
  parameter int C_AXI_ADDR_WIDTH = 10,
  parameter int NUM_CSR          = 4,
  parameter int FIFO_ELS         = 8
) (
  input  logic                          aclk,
  input  logic                          aresetn,

  input  logic [C_AXI_ADDR_WIDTH-1:0]   gp0_axi_awaddr,
  input  logic [2:0]                    gp0_axi_awprot,
  input  logic                          gp0_axi_awvalid,
  output logic                          gp0_axi_awready,
  input  logic [C_AXI_DATA_WIDTH-1:0]   gp0_axi_wdata,
  input  logic [C_AXI_DATA_WIDTH/8-1:0] gp0_axi_wstrb,
  input  logic                          gp0_axi_wvalid,
  output logic                          gp0_axi_wready,
  output logic [1:0]                    gp0_axi_bresp,
  output logic                          gp0_axi_bvalid,
  input  logic                          gp0_axi_bready,

  input  logic [C_AXI_ADDR_WIDTH-1:0]   gp0_axi_araddr,
  input  logic [2:0]                    gp0_axi_arprot,
  input  logic                          gp0_axi_arvalid,
  output logic                          gp0_axi_arready,
  output logic [C_AXI_DATA_WIDTH-1:0]   gp0_axi_rdata,
  output logic [1:0]                    gp0_axi_rresp,
  output logic                          gp0_axi_rvalid,
  input  logic                          gp0_axi_rready,

  output logic [NUM_CSR*32-1:0]         csr_data_o,
  output logic [31:0]                   ps2pl_data_o,
  output logic                          ps2pl_v_o,
  input  logic                          ps2pl_yumi_i,
  input  logic [31:0]                   pl2ps_data_i,
  input  logic                          pl2ps_v_i,
  output logic                          pl2ps_ready_o
);

  localparam int DW    = C_AXI_DATA_WIDTH;
  localparam int STRB_W = C_AXI_DATA_WIDTH / 8;
  localparam int CNT_W = cnt_w(FIFO_ELS);

  function automatic logic [DW-1:0] apply_strb(input logic [DW-1:0]     cur,
                                               input logic [DW-1:0]     upd,
                                               input logic [STRB_W-1:0] strb);
    logic [DW-1:0] merged;
    merged = cur;
    for (int b = 0; b < STRB_W; b++) begin
      if (strb[b]) merged[8*b +: 8] = upd[8*b +: 8];
    end
    return merged;
  endfunction

  logic              rst_done;
  logic              aw_held_p0;
  logic [5:0]        aw_idx_p0;
  logic              w_held_p0;
  logic [DW-1:0]     w_data_p0;
  logic [STRB_W-1:0] w_strb_p0;
  logic              bvld_p1;
  logic [1:0]        bresp_p1;
  logic              rvld_p1;
  logic [1:0]        rresp_p1;
  logic [DW-1:0]     rdata_p1;
  logic [DW-1:0]     csr_q [NUM_CSR];

  logic              aw_hs;
  logic              w_hs;
  logic              ar_hs;
  logic              wr_commit;
  logic              wr_is_csr;
  logic [1:0]        wr_resp;
  logic              ps_push;
  logic [5:0]        ar_idx;
  logic [DW-1:0]     rd_data;
  logic [1:0]        rd_resp;
  logic              rd_pop;

  logic [CNT_W-1:0]  ps_cnt;
  logic              ps_full;
  logic              ps_empty;
  logic [31:0]       pl_head;
  logic [CNT_W-1:0]  pl_cnt;
  logic              pl_full;
  logic              pl_empty;

  logic              unused_bits;
  assign unused_bits = ^{gp0_axi_awaddr[C_AXI_ADDR_WIDTH-1:8], gp0_axi_awaddr[1:0],
                         gp0_axi_araddr[C_AXI_ADDR_WIDTH-1:8], gp0_axi_araddr[1:0],
                         gp0_axi_awprot, gp0_axi_arprot};

  // Readies stay low until the first clock after reset release
  assign gp0_axi_awready = rst_done & ~aw_held_p0 & ~bvld_p1;
  assign gp0_axi_wready  = rst_done & ~w_held_p0 & ~bvld_p1;
  assign gp0_axi_arready = rst_done & ~rvld_p1;
  assign pl2ps_ready_o   = rst_done & ~pl_full;

  assign aw_hs = gp0_axi_awvalid & gp0_axi_awready;
  assign w_hs  = gp0_axi_wvalid & gp0_axi_wready;
  assign ar_hs = gp0_axi_arvalid & gp0_axi_arready;

  // ---- stage p0: write commit decode from the AW/W holding registers ----
  assign wr_commit = aw_held_p0 & w_held_p0;
  assign wr_is_csr = (int'(aw_idx_p0) < NUM_CSR);
  assign ps_push   = wr_commit & (aw_idx_p0 == IDX_PS2PL_PUSH);

  always_comb begin
    wr_resp = RESP_SLVERR;
    if (wr_is_csr) begin
      wr_resp = RESP_OKAY;
    end else begin
      case (aw_idx_p0)
        IDX_PS2PL_PUSH: wr_resp = ps_full ? RESP_SLVERR : RESP_OKAY;
        IDX_PS2PL_FREE: wr_resp = RESP_OKAY;
        IDX_PL2PS_OCC:  wr_resp = RESP_OKAY;
        default:        wr_resp = RESP_SLVERR;
      endcase
    end
  end

  // ---- stage p0: read decode, sampled in the AR handshake cycle ----
  assign ar_idx = gp0_axi_araddr[7:2];

  always_comb begin
    rd_data = '0;
    rd_resp = RESP_OKAY;
    rd_pop  = 1'b0;
    if (int'(ar_idx) < NUM_CSR) begin
      for (int i = 0; i < NUM_CSR; i++) begin
        if (ar_idx == 6'(i)) rd_data = csr_q[i];
      end
    end else begin
      case (ar_idx)
        IDX_PS2PL_PUSH: rd_data = '0;
        IDX_PS2PL_FREE: rd_data = DW'(CNT_W'(FIFO_ELS) - ps_cnt);
        IDX_PL2PS_OCC:  rd_data = DW'(pl_cnt);
        IDX_PL2PS_POP: begin
          if (!pl_empty) begin
            rd_data = DW'(pl_head);
            rd_pop  = 1'b1;
          end else begin
            rd_resp = RESP_SLVERR;
          end
        end
        default: rd_resp = RESP_SLVERR;
      endcase
    end
  end

  // ---- stage p1: handshake control and B/R response registers ----
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      rst_done   <= 1'b0;
      aw_held_p0 <= 1'b0;
      w_held_p0  <= 1'b0;
      bvld_p1    <= 1'b0;
      bresp_p1   <= RESP_OKAY;
      rvld_p1    <= 1'b0;
      rresp_p1   <= RESP_OKAY;
    end else begin
      rst_done <= 1'b1;

      if (wr_commit)  aw_held_p0 <= 1'b0;
      else if (aw_hs) aw_held_p0 <= 1'b1;

      if (wr_commit) w_held_p0 <= 1'b0;
      else if (w_hs) w_held_p0 <= 1'b1;

      if (wr_commit) begin
        bvld_p1  <= 1'b1;
        bresp_p1 <= wr_resp;
      end else if (gp0_axi_bready) begin
        bvld_p1 <= 1'b0;
      end

      if (ar_hs) begin
        rvld_p1  <= 1'b1;
        rresp_p1 <= rd_resp;
      end else if (gp0_axi_rready) begin
        rvld_p1 <= 1'b0;
      end
    end
  end

  always_ff @(posedge aclk) begin
    if (aw_hs) aw_idx_p0 <= gp0_axi_awaddr[7:2];
    if (w_hs) begin
      w_data_p0 <= gp0_axi_wdata;
      w_strb_p0 <= gp0_axi_wstrb;
    end
    if (ar_hs) rdata_p1 <= rd_data;
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      for (int i = 0; i < NUM_CSR; i++) csr_q[i] <= '0;
    end else if (wr_commit && wr_is_csr) begin
      for (int i = 0; i < NUM_CSR; i++) begin
        if (aw_idx_p0 == 6'(i)) csr_q[i] <= apply_strb(csr_q[i], w_data_p0, w_strb_p0);
      end
    end
  end

  for (genvar g = 0; g < NUM_CSR; g++) begin : g_csr_out
    assign csr_data_o[32*g +: 32] = csr_q[g][31:0];
  end

  assign gp0_axi_bvalid = bvld_p1;
  assign gp0_axi_bresp  = bresp_p1;
  assign gp0_axi_rvalid = rvld_p1;
  assign gp0_axi_rresp  = rresp_p1;
  assign gp0_axi_rdata  = rdata_p1;

  zynq_gp0_csr_fifo #(
    .DATA_W (32),
    .ELS    (FIFO_ELS)
  ) u_ps2pl_fifo (
    .clk       (aclk),
    .rst_n     (aresetn),
    .push      (ps_push),
    .push_data (w_data_p0[31:0]),
    .pop       (ps2pl_yumi_i),
    .head_data (ps2pl_data_o),
    .count     (ps_cnt),
    .full      (ps_full),
    .empty     (ps_empty)
  );

  assign ps2pl_v_o = ~ps_empty;

  zynq_gp0_csr_fifo #(
    .DATA_W (32),
    .ELS    (FIFO_ELS)
  ) u_pl2ps_fifo (
    .clk       (aclk),
    .rst_n     (aresetn),
    .push      (pl2ps_v_i & pl2ps_ready_o),
    .push_data (pl2ps_data_i),
    .pop       (ar_hs & rd_pop),
    .head_data (pl_head),
    .count     (pl_cnt),
    .full      (pl_full),
    .empty     (pl_empty)
  );

endmodule
